// File: rtl/matrix_vec_mul_pkg.sv
// Shared types and latency bounds for the 2x2 binary matrix-vector multiplier.
// Arithmetic mode is selected with MATRIX_VEC_MUL_BOOLEAN_EN (see dot2).
package matrix_vec_mul_pkg;

    typedef logic [1:0] row2_t;
    typedef logic [1:0] vec2_t;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 4;

endpackage

// File: rtl/matrix_vec_mul_dot2.sv
// Two-element binary dot product. Default is GF(2) (XOR accumulation);
// defining MATRIX_VEC_MUL_BOOLEAN_EN switches to the Boolean semiring (OR).
module dot2
    import matrix_vec_mul_pkg::*;
(
    input  row2_t r,
    input  vec2_t v,
    output logic  y
);

    logic [1:0] w_terms;

    assign w_terms = r & v;

`ifdef MATRIX_VEC_MUL_BOOLEAN_EN
    assign y = |w_terms;
`else
    assign y = ^w_terms;
`endif

endmodule

// File: rtl/matrix_vec_mul.sv
// 2x2 binary matrix times 2-bit vector, LATENCY-deep valid-qualified pipeline.
// Arithmetic chosen by MATRIX_VEC_MUL_BOOLEAN_EN (undefined: GF(2)).
module matrix_vec_mul
    import matrix_vec_mul_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    input  logic f,
    output logic g,
    output logic h,
    output logic out_valid
);

    generate
        if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_latency_check
            $error("matrix_vec_mul: LATENCY must be within 1..4");
        end
    endgenerate

    row2_t w_row0;
    row2_t w_row1;
    vec2_t w_vec;
    logic  w_g;
    logic  w_h;

    // Bit 0 of each row/vector is the column-0 element.
    assign w_row0 = {b, a};
    assign w_row1 = {d, c};
    assign w_vec  = {f, e};

    dot2 u_dot_row0 (
        .r (w_row0),
        .v (w_vec),
        .y (w_g)
    );

    dot2 u_dot_row1 (
        .r (w_row1),
        .v (w_vec),
        .y (w_h)
    );

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            logic r_valid;
            logic r_g;
            logic r_h;
            logic w_valid_in;
            logic w_g_in;
            logic w_h_in;

            if (gi == 0) begin : g_first
                assign w_valid_in = in_valid;
                assign w_g_in     = w_g;
                assign w_h_in     = w_h;
            end else begin : g_next
                assign w_valid_in = g_stage[gi-1].r_valid;
                assign w_g_in     = g_stage[gi-1].r_g;
                assign w_h_in     = g_stage[gi-1].r_h;
            end

            // Data only advances with its valid, so an empty stage keeps the last result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_g     <= 1'b0;
                    r_h     <= 1'b0;
                end else begin
                    r_valid <= w_valid_in;
                    if (w_valid_in) begin
                        r_g <= w_g_in;
                        r_h <= w_h_in;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[LATENCY-1].r_valid;
    assign g         = g_stage[LATENCY-1].r_g;
    assign h         = g_stage[LATENCY-1].r_h;

endmodule

// File: tb/tb_matrix_vec_mul.sv
// Scoreboard bench for matrix_vec_mul at LATENCY=3: every driven cycle pushes an
// expected entry, which is popped and compared when it reaches the output.
module tb_matrix_vec_mul;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic a, b, c, d, e, f;
    logic g, h, out_valid;

    always #5 clk = ~clk;

    matrix_vec_mul #(.LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .g         (g),
        .h         (h),
        .out_valid (out_valid)
    );

    typedef struct packed {
        logic v;
        logic g;
        logic h;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic model_g  = 1'b0;
    logic model_h  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // x = {a,b,c,d,e,f}; returns {g,h}
    function automatic logic [1:0] model(input logic [5:0] x);
        logic ma, mb, mc, md, me, mf;
        {ma, mb, mc, md, me, mf} = x;
`ifdef MATRIX_VEC_MUL_BOOLEAN_EN
        return {(ma & me) | (mb & mf), (mc & me) | (md & mf)};
`else
        return {(ma & me) ^ (mb & mf), (mc & me) ^ (md & mf)};
`endif
    endfunction

    task automatic step(input logic v, input logic [5:0] x, input string tag);
        logic [1:0] r;
        exp_t       ent;
        logic       exp_v;
        in_valid = v;
        {a, b, c, d, e, f} = x;
        @(posedge clk);
        #1;
        r = model(x);
        q.push_back('{v: v, g: r[1], h: r[0]});
        exp_v = 1'b0;
        if (q.size() >= LAT) begin
            ent = q.pop_front();
            if (ent.v) begin
                model_g = ent.g;
                model_h = ent.h;
                exp_v   = 1'b1;
            end
        end
        check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, exp_v});
        check({tag, "_g"}, {31'd0, g}, {31'd0, model_g});
        check({tag, "_h"}, {31'd0, h}, {31'd0, model_h});
        if (exp_v)
            $display("txn %s: out_valid=%b g=%b h=%b (expected g=%b h=%b)",
                     tag, out_valid, g, h, model_g, model_h);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++)
            step(1'b0, 6'($urandom_range(0, 63)), tag);
    endtask

    // Asserts reset between clock edges and checks outputs clear without a clock edge.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_rst_g"}, {31'd0, g}, 32'd0);
        check({tag, "_rst_h"}, {31'd0, h}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        model_g = 1'b0;
        model_h = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        {a, b, c, d, e, f} = 6'd0;
        #12;
        check("init_valid", {31'd0, out_valid}, 32'd0);
        check("init_g", {31'd0, g}, 32'd0);
        check("init_h", {31'd0, h}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // identity matrix, v = [1 0]
        step(1'b1, 6'b100110, "identity");
        idle(LAT + 1, "identity_idle");

        step(1'b1, 6'b111111, "cancel");
        idle(LAT + 1, "cancel_idle");

        step(1'b1, 6'b100010, "bubble_first");
        step(1'b0, 6'($urandom_range(0, 63)), "bubble_gap");
        step(1'b1, 6'b010001, "bubble_last");
        idle(LAT + 1, "bubble_idle");

        for (int i = 0; i < 64; i++)
            step(1'b1, 6'(i), $sformatf("exh%0d", i));
        do_reset("midstream");
        idle(LAT + 2, "midstream_after");

        step(1'b1, 6'($urandom_range(0, 63)), "flush_in0");
        step(1'b1, 6'($urandom_range(0, 63)), "flush_in1");
        do_reset("flush");
        idle(LAT + 2, "flush_after");

        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $sformatf("rand%0d", i));
        idle(LAT + 1, "rand_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
